// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports and two clocked write ports.
// A per-register busy scoreboard raises hazard on RAW/WAW conflicts and counts stall cycles.
module reg_file_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en0,
    input  logic [ADDR_WIDTH-1:0] wr_addr0,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic                  wr_en1,
    input  logic [ADDR_WIDTH-1:0] wr_addr1,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_dst,
    input  logic                  iss_dst_en,
    input  logic [ADDR_WIDTH-1:0] iss_src1,
    input  logic [ADDR_WIDTH-1:0] iss_src2,
    input  logic                  iss_src2_en,
    output logic                  hazard,
    output logic                  iss_accept,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      wr_clr;
    logic [DEPTH-1:0]      eff_busy;
    logic                  we0;
    logic                  we1;
    logic                  dst_set;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + CNT_WIDTH'(1);
    endfunction

    // With ZERO_REG, writes to R0 are dropped before they reach the array or scoreboard.
    assign we0 = wr_en0 && !(ZERO_REG && wr_addr0 == '0);
    assign we1 = wr_en1 && !(ZERO_REG && wr_addr1 == '0);

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
        if (ZERO_REG && a == '0) return '0;
        if (BYPASS && we1 && wr_addr1 == a) return wr_data1;
        if (BYPASS && we0 && wr_addr0 == a) return wr_data0;
        return regs[a];
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

    always_comb begin
        wr_clr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_clr[i] = (we0 && wr_addr0 == ADDR_WIDTH'(i)) || (we1 && wr_addr1 == ADDR_WIDTH'(i));
        end
        // A register whose writeback lands this cycle is already readable through the bypass.
        eff_busy = BYPASS ? (busy & ~wr_clr) : busy;
    end

    assign hazard = iss_valid && (eff_busy[iss_src1]
                                  || (iss_src2_en && eff_busy[iss_src2])
                                  || (iss_dst_en && eff_busy[iss_dst]));
    assign iss_accept = iss_valid && !hazard;
    assign dst_set    = iss_accept && iss_dst_en && !(ZERO_REG && iss_dst == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (we0) regs[wr_addr0] <= wr_data0;
            if (we1) regs[wr_addr1] <= wr_data1;
        end
    end

    // A new reservation beats a writeback release on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dst_set && iss_dst == ADDR_WIDTH'(i)) busy[i] <= 1'b1;
                else if (wr_clr[i])                       busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 stall_cnt <= '0;
        else if (iss_valid && hazard) stall_cnt <= sat_inc(stall_cnt);
    end
endmodule
